// File: rtl/pack_loader.sv
// pack_loader: packs a stream of WORD_W-bit host words into DATASIZE-bit
// option records and writes them to consecutive addresses of the shared
// record BRAM. It owns the write port only after addrSelect grants it.
// DONE_WRITING pulses once the batch is fully written.
`timescale 1ns/1ps
module pack_loader #(
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned DATASIZE    = 192,
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned MAX_RECORDS = 1000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                addrSelect,
   input  logic                in_valid,
   input  logic [WORD_W-1:0]   in_data,
   input  logic                in_last,
   output logic                in_ready,
   output logic                writeEn,
   output logic [ADDR_W-1:0]   writeAddr,
   output logic [DATASIZE-1:0] writeData,
   output logic                DONE_WRITING,
   output logic [ADDR_W-1:0]   recordCount,
   output logic                frameErr
);

   localparam int unsigned WORDS  = DATASIZE / WORD_W;
   localparam int unsigned WCNT_W = $clog2(WORDS + 1);
   localparam int unsigned SLOT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   // One spare bit so a count of exactly 2^ADDR_W records is representable.
   localparam int unsigned RCNT_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   state_e                          state_q,    state_d;
   logic [WCNT_W-1:0]               word_cnt_q, word_cnt_d;
   logic [RCNT_W-1:0]               rec_cnt_q,  rec_cnt_d;
   logic [WORDS-1:0][WORD_W-1:0]    pack_q,     pack_d;
   logic                            eob_q,      eob_d;
   logic                            ferr_q,     ferr_d;
   logic                            ready_q,    ready_d;
   logic                            wen_q,      wen_d;
   logic [ADDR_W-1:0]               waddr_q,    waddr_d;
   logic                            done_q,     done_d;

   logic                            accept_c;
   logic                            last_word_c;
   logic [SLOT_W-1:0]               slot_c;
   logic [RCNT_W-1:0]               rec_next_c;

   // Handshake qualifiers, packing slot for the next word and saturating count.
   always_comb begin
      accept_c    = in_valid & ready_q;
      last_word_c = (word_cnt_q == WCNT_W'(WORDS - 1));
      slot_c      = SLOT_W'(WORDS - 1) - SLOT_W'(word_cnt_q);
      rec_next_c  = (rec_cnt_q == RCNT_W'(MAX_RECORDS)) ? rec_cnt_q
                                                         : rec_cnt_q + RCNT_W'(1);
   end

   // Next-state and next-output logic; outputs are registered from *_d.
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      rec_cnt_d  = rec_cnt_q;
      pack_d     = pack_q;
      eob_d      = eob_q;
      ferr_d     = ferr_q;
      waddr_d    = waddr_q;

      case (state_q)
         S_IDLE: begin
            if (addrSelect) begin
               state_d    = S_COLLECT;
               word_cnt_d = '0;
               rec_cnt_d  = '0;
               ferr_d     = 1'b0;
               eob_d      = 1'b0;
            end
         end

         S_COLLECT: begin
            if (accept_c) begin
               word_cnt_d = word_cnt_q + WCNT_W'(1);
               // First word of a record clears the register so a short record
               // is zero-filled below its last word.
               if (word_cnt_q == '0) begin
                  pack_d = '0;
               end
               pack_d[slot_c] = in_data;
               if (in_last) begin
                  eob_d = 1'b1;
               end
               if (last_word_c || in_last) begin
                  state_d = S_WRITE;
                  waddr_d = ADDR_W'(rec_cnt_q);
                  if (!last_word_c) begin
                     ferr_d = 1'b1;
                  end
               end
            end
         end

         S_WRITE: begin
            rec_cnt_d  = rec_next_c;
            word_cnt_d = '0;
            if (eob_q || (rec_next_c == RCNT_W'(MAX_RECORDS))) begin
               state_d = S_DONE;
            end else begin
               state_d = S_COLLECT;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            eob_d   = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d = (state_d == S_COLLECT);
      wen_d   = (state_d == S_WRITE);
      done_d  = (state_d == S_DONE);
   end

   // State and output registers; reset aborts any batch in progress.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         word_cnt_q <= '0;
         rec_cnt_q  <= '0;
         pack_q     <= '0;
         eob_q      <= 1'b0;
         ferr_q     <= 1'b0;
         ready_q    <= 1'b0;
         wen_q      <= 1'b0;
         waddr_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         rec_cnt_q  <= rec_cnt_d;
         pack_q     <= pack_d;
         eob_q      <= eob_d;
         ferr_q     <= ferr_d;
         ready_q    <= ready_d;
         wen_q      <= wen_d;
         waddr_q    <= waddr_d;
         done_q     <= done_d;
      end
   end

   assign in_ready     = ready_q;
   assign writeEn      = wen_q;
   assign writeAddr    = waddr_q;
   assign writeData    = pack_q;
   assign DONE_WRITING = done_q;
   assign recordCount  = ADDR_W'(rec_cnt_q);
   assign frameErr     = ferr_q;

endmodule

// File: tb/tb_pack_loader.sv
// Bench for pack_loader: directed scenarios plus randomized batches checked
// against a word-chunking reference model.
`timescale 1ns/1ps
module tb_pack_loader;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned DATASIZE = 192;
   localparam int unsigned ADDR_W   = 11;
   localparam int unsigned MAXR     = 4;
   localparam int unsigned WORDS    = DATASIZE / WORD_W;

   logic                clock = 1'b0;
   logic                reset = 1'b0;
   logic                addrSelect = 1'b0;
   logic                in_valid = 1'b0;
   logic [WORD_W-1:0]   in_data = '0;
   logic                in_last = 1'b0;
   logic                in_ready;
   logic                writeEn;
   logic [ADDR_W-1:0]   writeAddr;
   logic [DATASIZE-1:0] writeData;
   logic                DONE_WRITING;
   logic [ADDR_W-1:0]   recordCount;
   logic                frameErr;

   int total = 0;
   int bad   = 0;

   pack_loader #(
      .WORD_W(WORD_W), .DATASIZE(DATASIZE), .ADDR_W(ADDR_W), .MAX_RECORDS(MAXR)
   ) dut (
      .clock(clock), .reset(reset), .addrSelect(addrSelect),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .writeEn(writeEn), .writeAddr(writeAddr),
      .writeData(writeData), .DONE_WRITING(DONE_WRITING),
      .recordCount(recordCount), .frameErr(frameErr)
   );

   always #5 clock = ~clock;

   // Monitor state
   int cyc = 0;
   int acc_cnt, first_acc, last_acc, done_cnt, done_cyc, ready_hi;
   logic [ADDR_W-1:0]   done_rc;
   logic                done_fe;
   logic [ADDR_W-1:0]   wr_addr_q[$];
   logic [DATASIZE-1:0] wr_data_q[$];
   int                  wr_cyc_q[$];

   // Stimulus and model state
   logic [WORD_W-1:0]   words[$];
   bit                  lasts[$];
   logic [DATASIZE-1:0] exp_rec[$];
   int                  exp_acc;
   bit                  exp_fe;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (in_ready) ready_hi++;
      if (in_valid && in_ready) begin
         acc_cnt++;
         if (first_acc < 0) first_acc = cyc;
         last_acc = cyc;
      end
      if (writeEn) begin
         wr_addr_q.push_back(writeAddr);
         wr_data_q.push_back(writeData);
         wr_cyc_q.push_back(cyc);
      end
      if (DONE_WRITING) begin
         done_cnt++;
         done_cyc = cyc;
         done_rc  = recordCount;
         done_fe  = frameErr;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      acc_cnt = 0; first_acc = -1; last_acc = -1; done_cnt = 0; done_cyc = -1;
      ready_hi = 0; done_rc = '0; done_fe = 1'b0;
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
   endtask

   // Reference: chunk words into records until in_last or MAXR records.
   function automatic void build_model();
      logic [DATASIZE-1:0] rec;
      int k;
      exp_rec.delete(); exp_acc = 0; exp_fe = 1'b0; rec = '0; k = 0;
      foreach (words[i]) begin
         if (exp_rec.size() == int'(MAXR)) break;
         rec = rec | (DATASIZE'(words[i]) << (int'(DATASIZE) - (k + 1) * int'(WORD_W)));
         k++; exp_acc++;
         if (k == int'(WORDS) || lasts[i]) begin
            if (k < int'(WORDS)) exp_fe = 1'b1;
            exp_rec.push_back(rec);
            rec = '0; k = 0;
            if (lasts[i]) break;
         end
      end
   endfunction

   // Grants the port, offers words[] (with optional stalls) and releases the
   // grant on DONE_WRITING; keeps offering leftovers a few cycles afterwards.
   task automatic run_batch(input int stall_pct);
      int idx = 0;
      int n = words.size();
      int d0 = done_cnt;
      int post = 0;
      bit acc;
      addrSelect = 1'b1;
      for (int c = 0; c < 500; c++) begin
         if (done_cnt != d0) begin
            addrSelect = 1'b0;
            post++;
            if (post > 8) break;
         end
         if (idx < n && ($urandom_range(99) >= stall_pct)) begin
            in_valid = 1'b1; in_data = words[idx]; in_last = lasts[idx];
         end else begin
            in_valid = 1'b0; in_last = 1'b0; in_data = $urandom;
         end
         @(negedge clock);
         acc = in_valid && in_ready;
         if (acc) idx++;
         @(posedge clock); #1;
      end
      in_valid = 1'b0; in_last = 1'b0; addrSelect = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      total++; if ({in_ready, writeEn, DONE_WRITING, frameErr} !== 4'b0) begin
         bad++; $display("FAIL reset_flags: got %b want 0000", {in_ready, writeEn, DONE_WRITING, frameErr});
      end
      total++; if (writeAddr !== '0) begin
         bad++; $display("FAIL reset_addr: got %0h want 0", writeAddr);
      end
      total++; if (writeData !== '0) begin
         bad++; $display("FAIL reset_data: got %0h want 0", writeData);
      end
      total++; if (recordCount !== '0) begin
         bad++; $display("FAIL reset_count: got %0d want 0", recordCount);
      end
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_no_grant();
      clear_mon();
      addrSelect = 1'b0; in_valid = 1'b1; in_data = 32'hdead_beef; in_last = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
      total++; if (ready_hi !== 0) begin
         bad++; $display("FAIL nogrant_ready: got %0d ready cycles want 0", ready_hi);
      end
      total++; if (wr_addr_q.size() !== 0) begin
         bad++; $display("FAIL nogrant_write: got %0d writes want 0", wr_addr_q.size());
      end
      total++; if (done_cnt !== 0) begin
         bad++; $display("FAIL nogrant_done: got %0d pulses want 0", done_cnt);
      end
   endtask

   task automatic test_single();
      logic [DATASIZE-1:0] expd;
      expd = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
      clear_mon();
      words.delete(); lasts.delete();
      for (int i = 1; i <= 6; i++) begin words.push_back(WORD_W'(i)); lasts.push_back(i == 6); end
      run_batch(0);
      total++; if (wr_addr_q.size() !== 1) begin
         bad++; $display("FAIL single_nwr: got %0d want 1", wr_addr_q.size());
      end else begin
         total++; if (wr_addr_q[0] !== '0 || wr_data_q[0] !== expd) begin
            bad++; $display("FAIL single_rec: got addr %0d data %0h want addr 0 data %0h", wr_addr_q[0], wr_data_q[0], expd);
         end
         total++; if (wr_cyc_q[0] !== last_acc + 1) begin
            bad++; $display("FAIL single_wr_lat: got cycle %0d want %0d", wr_cyc_q[0], last_acc + 1);
         end
      end
      total++; if (done_cnt !== 1 || done_cyc !== last_acc + 2) begin
         bad++; $display("FAIL single_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc, last_acc + 2);
      end
      total++; if (done_rc !== 11'd1 || done_fe !== 1'b0) begin
         bad++; $display("FAIL single_cnt: got count %0d ferr %0b want 1 0", done_rc, done_fe);
      end
      total++; if (recordCount !== 11'd1) begin
         bad++; $display("FAIL single_hold: got %0d want 1", recordCount);
      end
   endtask

   task automatic test_back_to_back();
      clear_mon();
      words.delete(); lasts.delete();
      for (int i = 1; i <= 12; i++) begin words.push_back(WORD_W'(i)); lasts.push_back(i == 12); end
      build_model();
      run_batch(0);
      total++; if (wr_addr_q.size() !== 2) begin
         bad++; $display("FAIL b2b_nwr: got %0d want 2", wr_addr_q.size());
      end
      for (int i = 0; i < exp_rec.size() && i < wr_addr_q.size(); i++) begin
         total++; if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_rec[i]) begin
            bad++; $display("FAIL b2b_rec%0d: got addr %0d data %0h want addr %0d data %0h", i, wr_addr_q[i], wr_data_q[i], i, exp_rec[i]);
         end
      end
      total++; if (last_acc - first_acc !== 12 || acc_cnt !== 12) begin
         bad++; $display("FAIL b2b_gap: got span %0d accepts %0d want 12 12", last_acc - first_acc, acc_cnt);
      end
      total++; if (done_rc !== 11'd2) begin
         bad++; $display("FAIL b2b_cnt: got %0d want 2", done_rc);
      end
   endtask

   task automatic test_short();
      clear_mon();
      words.delete(); lasts.delete();
      for (int i = 0; i < 3; i++) begin words.push_back($urandom); lasts.push_back(i == 2); end
      build_model();
      run_batch(0);
      total++; if (wr_addr_q.size() !== 1 || wr_data_q[0] !== {words[0], words[1], words[2], 96'd0}) begin
         bad++; $display("FAIL short_rec: got %0d writes data %0h want 1 %0h", wr_addr_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : '0, {words[0], words[1], words[2], 96'd0});
      end
      total++; if (done_cnt !== 1 || done_fe !== 1'b1 || frameErr !== 1'b1) begin
         bad++; $display("FAIL short_ferr: got pulses %0d ferr %0b/%0b want 1 1/1", done_cnt, done_fe, frameErr);
      end
      addrSelect = 1'b1;
      @(posedge clock); #1;
      total++; if (frameErr !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL short_clear: got ferr %0b ready %0b want 0 1", frameErr, in_ready);
      end
      words.delete(); lasts.delete();
      for (int i = 0; i < 6; i++) begin words.push_back($urandom); lasts.push_back(i == 5); end
      run_batch(0);
   endtask

   task automatic test_overflow();
      clear_mon();
      words.delete(); lasts.delete();
      for (int i = 0; i < 30; i++) begin words.push_back($urandom); lasts.push_back(1'b0); end
      build_model();
      run_batch(0);
      total++; if (wr_addr_q.size() !== int'(MAXR)) begin
         bad++; $display("FAIL ovf_nwr: got %0d want %0d", wr_addr_q.size(), MAXR);
      end
      for (int i = 0; i < exp_rec.size() && i < wr_addr_q.size(); i++) begin
         total++; if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_rec[i]) begin
            bad++; $display("FAIL ovf_rec%0d: got addr %0d data %0h want addr %0d data %0h", i, wr_addr_q[i], wr_data_q[i], i, exp_rec[i]);
         end
      end
      total++; if (acc_cnt !== 24 || done_cnt !== 1) begin
         bad++; $display("FAIL ovf_accept: got accepts %0d pulses %0d want 24 1", acc_cnt, done_cnt);
      end
      total++; if (recordCount !== 11'd4 || done_rc !== 11'd4) begin
         bad++; $display("FAIL ovf_cnt: got %0d/%0d want 4/4", recordCount, done_rc);
      end
   endtask

   task automatic test_reset_mid();
      clear_mon();
      addrSelect = 1'b1;
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      reset = 1'b0;
      #1;
      total++; if ({in_ready, writeEn, DONE_WRITING, frameErr} !== 4'b0 || recordCount !== '0 || writeData !== '0 || writeAddr !== '0) begin
         bad++; $display("FAIL midrst_outs: got flags %b count %0d data %0h want all 0", {in_ready, writeEn, DONE_WRITING, frameErr}, recordCount, writeData);
      end
      addrSelect = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      total++; if (wr_addr_q.size() !== 0 || done_cnt !== 0 || acc_cnt !== 3) begin
         bad++; $display("FAIL midrst_abort: got writes %0d pulses %0d accepts %0d want 0 0 3", wr_addr_q.size(), done_cnt, acc_cnt);
      end
      clear_mon();
      words.delete(); lasts.delete();
      for (int i = 0; i < 6; i++) begin words.push_back($urandom); lasts.push_back(i == 5); end
      build_model();
      run_batch(20);
      total++; if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== '0 || wr_data_q[0] !== exp_rec[0]) begin
         bad++; $display("FAIL midrst_regrant: got %0d writes want 1 at addr 0 data %0h", wr_addr_q.size(), exp_rec[0]);
      end
   endtask

   task automatic test_random();
      int len, p;
      for (int b = 0; b < 12; b++) begin
         clear_mon();
         words.delete(); lasts.delete();
         len = $urandom_range(30, 1);
         p = (len < 24 || $urandom_range(1)) ? $urandom_range(len - 1, 0) : -1;
         for (int i = 0; i < len; i++) begin words.push_back($urandom); lasts.push_back(i == p); end
         build_model();
         run_batch(30);
         total++; if (wr_addr_q.size() !== exp_rec.size() || done_cnt !== 1) begin
            bad++; $display("FAIL rand%0d_nwr: got %0d writes %0d pulses want %0d 1", b, wr_addr_q.size(), done_cnt, exp_rec.size());
         end
         for (int i = 0; i < exp_rec.size() && i < wr_addr_q.size(); i++) begin
            total++; if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_rec[i]) begin
               bad++; $display("FAIL rand%0d_rec%0d: got addr %0d data %0h want addr %0d data %0h", b, i, wr_addr_q[i], wr_data_q[i], i, exp_rec[i]);
            end
         end
         total++; if (acc_cnt !== exp_acc || done_rc !== ADDR_W'(exp_rec.size()) || done_fe !== exp_fe) begin
            bad++; $display("FAIL rand%0d_stat: got acc %0d cnt %0d ferr %0b want %0d %0d %0b", b, acc_cnt, done_rc, done_fe, exp_acc, exp_rec.size(), exp_fe);
         end
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_no_grant();
      test_single();
      test_back_to_back();
      test_short();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pack_loader.md
# pack_loader

Upstream feeder for the data manager. Accepts a stream of 32-bit words from the host link and packs every 6 words into one 192-bit option record. Writes each record into the shared record BRAM at consecutive addresses, then pulses `DONE_WRITING` so the data manager starts serving records to the Black-Scholes modules. Owns the BRAM write port only while the data manager signals loader ownership through `addrSelect`.

## Interface
- `WORD_W`, 32, input word width
- `DATASIZE`, 192, record width; must be an integer multiple of `WORD_W` (6 words at defaults)
- `ADDR_W`, 11, BRAM address width
- `MAX_RECORDS`, 1000, batch capacity; must be ≤ 2^`ADDR_W`

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low (asserted at 0)
- `addrSelect`  in  1  from data manager; 1 = loader owns BRAM port
- `in_valid`  in  1  word on `in_data` is valid
- `in_data`  in  `WORD_W`  input word
- `in_last`  in  1  qualifies the final word of a batch
- `in_ready`  out  1  loader accepts a word this cycle
- `writeEn`  out  1  BRAM write strobe
- `writeAddr`  out  `ADDR_W`  BRAM write address (record index)
- `writeData`  out  `DATASIZE`  packed record
- `DONE_WRITING`  out  1  one-cycle pulse: batch fully in BRAM
- `recordCount`  out  `ADDR_W`  records written in current/last batch
- `frameErr`  out  1  sticky: `in_last` arrived mid-record

## Operation
- A word is accepted when `in_valid & in_ready` at a rising edge. No other cycle consumes a word.
- Packing: the first word of a record lands in `[DATASIZE-1 : DATASIZE-WORD_W]` and each later word shifts in below it. The 6th word lands in `[WORD_W-1:0]`.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: `in_ready`=0.
  - If `addrSelect`=1: go to COLLECT, and clear the word counter, `recordCount` and `frameErr`.
  - Otherwise stay in IDLE.
- COLLECT: `in_ready`=1.
  - Each accepted word increments the word counter.
  - Go to WRITE when the 6th word is accepted.
  - Also go to WRITE when a word with `in_last`=1 is accepted before word 6. In that case the remaining lower words are zero-filled and `frameErr` is set.
  - An accepted `in_last` is latched as end-of-batch.
- WRITE: `in_ready`=0 and `writeEn`=1 for exactly one cycle, with `writeAddr`=`recordCount` and `writeData`=packed record.
  - At the edge ending WRITE, `recordCount` increments.
  - Go to DONE if end-of-batch is latched or the new count equals `MAX_RECORDS`.
  - Otherwise go to COLLECT with the word counter cleared.
- DONE: `DONE_WRITING`=1 for one cycle, `in_ready`=0, then go to IDLE.
  - The data manager leaves its no-data state on this pulse and drops `addrSelect`.
  - Because `addrSelect` is low on return to IDLE, no new batch starts until the data manager re-grants the port.
- Overflow: after `MAX_RECORDS` records the batch closes without `in_last`. Further words are not accepted until the next grant.
- `addrSelect` falling during COLLECT or WRITE is a protocol error and is ignored. The loader completes its current record and batch.
- Width rules:
  - `recordCount` saturates at `MAX_RECORDS`; it never wraps.
  - `writeAddr` is always < `MAX_RECORDS`.
  - BRAM entries at or above `recordCount` keep stale contents.
- `writeData` is meaningful only while `writeEn`=1. It holds the packing register otherwise.

## Timing
- Reset value of every output: 0, with state IDLE, the packing register cleared and end-of-batch cleared.
- Reset mid-operation aborts immediately:
  - a partial record is discarded and no write is issued;
  - no `DONE_WRITING` pulse is produced;
  - the next batch starts at address 0.
- IDLE → COLLECT takes 1 cycle after `addrSelect` is sampled high. `in_ready` rises in the first COLLECT cycle.
- 6th (or `in_last`) word accepted at edge N:
  - `writeEn` is high in cycle N+1;
  - `DONE_WRITING` is high in cycle N+2 if the batch ends.
- Throughput is 6 words per 7 cycles with `in_ready` low during each WRITE cycle. Source stalls (`in_valid`=0) are allowed at any point and only extend COLLECT.
- `recordCount` updates at the edge ending WRITE. During the DONE cycle it shows the final count, and holds that value until the next IDLE → COLLECT transition.

## Test plan
- Grant, then words 1..6 back-to-back with `in_last` on word 6 → single `writeEn` at `writeAddr`=0 with `writeData`={32'd1,…,32'd6}, 32'd1 in the top bits. `DONE_WRITING` is high 2 cycles after the last accept for 1 cycle, `recordCount`=1, `frameErr`=0.
- `addrSelect`=0 held while `in_valid`=1 for 20 cycles → `in_ready` stays 0, no `writeEn`, no `DONE_WRITING`.
- Grant, then 12 continuous words 1..12 with `in_last` on word 12 → writes at addr 0 (1..6) and addr 1 (7..12). `in_ready` is low exactly one cycle after word 6, `recordCount`=2.
- Grant, then words A,B,C with `in_last` on C → record {A,B,C,0,0,0} at addr 0, `frameErr`=1, `DONE_WRITING` pulse. `frameErr` clears on the next grant.
- `MAX_RECORDS`=4, grant, then 30 words with no `in_last` → writes at addr 0..3 with `DONE_WRITING` after the 4th write. `in_ready` stays 0 afterwards, 24 words consumed, `recordCount`=4.
- Grant, then 3 words, then `reset` pulsed low → no `writeEn`, no `DONE_WRITING`, all outputs 0. After a re-grant, 6 words write to addr 0.
